// File: rtl/layer_mac_sequencer_pkg.sv
// Shared widths, special sector/address codes, FSM encoding and layer config payload
// for the dense-layer MAC sequencer.
package layer_mac_sequencer_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_FRAC_W = 8;
    localparam int unsigned DEF_ACC_W  = 40;
    localparam int unsigned DEF_RD_LAT = 1;

    localparam int unsigned SECT_W = 4;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned NOUT_W = 5;
    localparam int unsigned LAST_W = NOUT_W + 1;

    localparam logic [SECT_W-1:0] ROM_SECTOR = 4'd15;
    localparam logic [ADDR_W-1:0] BIAS_ADDR  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [SECT_W-1:0] in_sector;
        logic [SECT_W-1:0] w_sector_base;
        logic [SECT_W-1:0] out_sector;
        logic [ADDR_W-1:0] n_inputs;
        logic [NOUT_W-1:0] n_outputs;
        logic              relu_en;
    } layer_cfg_t;

    // Configurations that would read the bias slot as data, write the ROM, overwrite
    // the inputs, or run the weight sectors past sector 15.
    function automatic logic cfg_illegal(input layer_cfg_t cfg);
        logic [LAST_W-1:0] w_end;
        w_end = LAST_W'(cfg.w_sector_base) + LAST_W'(cfg.n_outputs);
        return (cfg.n_inputs == '0) || (cfg.n_inputs >= BIAS_ADDR)
            || (cfg.n_outputs == '0) || (cfg.n_outputs > 5'd16)
            || (cfg.out_sector == ROM_SECTOR)
            || (cfg.out_sector == cfg.in_sector)
            || (w_end > 6'd16);
    endfunction

endpackage

// File: rtl/layer_mac_sequencer_mac_q88.sv
// Signed fixed-point MAC: accumulates x*w products and the shifted bias, then
// rounds, saturates to the word range and optionally applies ReLU.
module layer_mac_sequencer_mac_q88
    import layer_mac_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned FRAC_W = DEF_FRAC_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              acc_en,
    input  logic              is_bias,
    input  logic              relu_en,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    output logic [DATA_W-1:0] result_c
);

    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) <<< (FRAC_W - 1);
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-(1 << (DATA_W - 1)));

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    term;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    rounded;
    logic        [DATA_W-1:0]   sat;

    // result_c reflects the accumulator including the term consumed this cycle
    always_comb begin
        prod = $signed(x) * $signed(w);
        if (is_bias) begin
            term = $signed({{(ACC_W-DATA_W){w[DATA_W-1]}}, w}) <<< FRAC_W;
        end else begin
            term = $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});
        end
        acc_d   = acc_en ? (acc_q + term) : acc_q;
        rounded = (acc_d + HALF) >>> FRAC_W;
        if (rounded > MAX_V) begin
            sat = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (rounded < MIN_V) begin
            sat = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat = rounded[DATA_W-1:0];
        end
        result_c = (relu_en && sat[DATA_W-1]) ? '0 : sat;
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/layer_mac_sequencer.sv
// Runs one dense layer: streams inputs and weight rows from the sector memory,
// accumulates each neuron through the MAC and writes the results back.
module layer_mac_sequencer
    import layer_mac_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned FRAC_W = DEF_FRAC_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [SECT_W-1:0] in_sector,
    input  logic [SECT_W-1:0] w_sector_base,
    input  logic [SECT_W-1:0] out_sector,
    input  logic [ADDR_W-1:0] n_inputs,
    input  logic [NOUT_W-1:0] n_outputs,
    input  logic              relu_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] read_add_1,
    output logic [SECT_W-1:0] read_sector_selector_1,
    output logic [ADDR_W-1:0] read_add_2,
    output logic [SECT_W-1:0] read_sector_selector_2,
    input  logic [DATA_W-1:0] read_data_1,
    input  logic [DATA_W-1:0] read_data_2,
    output logic [DATA_W-1:0] data_write,
    output logic [SECT_W-1:0] sector_write_select,
    output logic [ADDR_W-1:0] write_address,
    output logic              en_write
);

    state_t            state, state_d;
    layer_cfg_t        cfg, cfg_d, start_cfg;
    logic [ADDR_W-1:0] cnt, cnt_d;
    logic [NOUT_W-1:0] j, j_d;

    logic              busy_d, done_d, err_d, en_write_d;
    logic [ADDR_W-1:0] ra1_d, ra2_d, wa_d;
    logic [SECT_W-1:0] rs1_d, rs2_d, sws_d;
    logic [DATA_W-1:0] dw_d;

    logic              issue_valid, issue_bias;
    logic              pipe_valid, pipe_bias;
    logic              mac_clear;
    logic [DATA_W-1:0] result_c;

    assign start_cfg = {in_sector, w_sector_base, out_sector, n_inputs, n_outputs, relu_en};

    // Tags each issued read so the MAC knows when its data lands and whether it is the bias
    if (RD_LAT == 0) begin : g_no_pipe
        assign pipe_valid = issue_valid;
        assign pipe_bias  = issue_bias;
    end else begin : g_pipe
        logic [RD_LAT-1:0] valid_q, bias_q;
        always_ff @(posedge clock) begin
            if (reset) begin
                valid_q <= '0;
                bias_q  <= '0;
            end else begin
                valid_q[0] <= issue_valid;
                bias_q[0]  <= issue_bias;
                for (int k = 1; k < int'(RD_LAT); k++) begin
                    valid_q[k] <= valid_q[k-1];
                    bias_q[k]  <= bias_q[k-1];
                end
            end
        end
        assign pipe_valid = valid_q[RD_LAT-1];
        assign pipe_bias  = bias_q[RD_LAT-1];
    end

    layer_mac_sequencer_mac_q88 #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clock    (clock),
        .reset    (reset),
        .clear    (mac_clear),
        .acc_en   (pipe_valid),
        .is_bias  (pipe_bias),
        .relu_en  (cfg.relu_en),
        .x        (read_data_1),
        .w        (read_data_2),
        .result_c (result_c)
    );

    always_comb begin
        state_d     = state;
        cfg_d       = cfg;
        cnt_d       = cnt;
        j_d         = j;
        busy_d      = busy;
        done_d      = 1'b0;
        err_d       = 1'b0;
        en_write_d  = 1'b0;
        ra1_d       = read_add_1;
        rs1_d       = read_sector_selector_1;
        ra2_d       = read_add_2;
        rs2_d       = read_sector_selector_2;
        dw_d        = data_write;
        sws_d       = sector_write_select;
        wa_d        = write_address;
        issue_valid = 1'b0;
        issue_bias  = 1'b0;
        mac_clear   = 1'b0;

        case (state)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    cfg_d  = start_cfg;
                    busy_d = 1'b1;
                    if (cfg_illegal(start_cfg)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        cnt_d   = '0;
                        j_d     = '0;
                        ra1_d   = '0;
                        ra2_d   = '0;
                        rs1_d   = in_sector;
                        rs2_d   = w_sector_base;
                        sws_d   = out_sector;
                        wa_d    = '0;
                    end
                end
            end
            // Addresses for the next issue slot are registered one cycle ahead
            ST_ISSUE: begin
                issue_valid = 1'b1;
                issue_bias  = (cnt == cfg.n_inputs);
                if (issue_bias) begin
                    cnt_d = '0;
                    if (RD_LAT == 0) begin
                        state_d    = ST_WRITE;
                        en_write_d = 1'b1;
                        dw_d       = result_c;
                        wa_d       = j[ADDR_W-1:0];
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    cnt_d = cnt + 4'd1;
                    ra1_d = cnt + 4'd1;
                    ra2_d = ((cnt + 4'd1) == cfg.n_inputs) ? BIAS_ADDR : (cnt + 4'd1);
                end
            end
            ST_DRAIN: begin
                if (cnt == 4'(RD_LAT - 1)) begin
                    state_d    = ST_WRITE;
                    en_write_d = 1'b1;
                    dw_d       = result_c;
                    wa_d       = j[ADDR_W-1:0];
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            ST_WRITE: begin
                mac_clear = 1'b1;
                if (j == (cfg.n_outputs - 5'd1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_ISSUE;
                    j_d     = j + 5'd1;
                    cnt_d   = '0;
                    ra1_d   = '0;
                    ra2_d   = '0;
                    rs1_d   = cfg.in_sector;
                    rs2_d   = cfg.w_sector_base + 4'(j + 5'd1);
                    sws_d   = cfg.out_sector;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                  <= ST_IDLE;
            cfg                    <= '0;
            cnt                    <= '0;
            j                      <= '0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            err                    <= 1'b0;
            en_write               <= 1'b0;
            read_add_1             <= '0;
            read_sector_selector_1 <= '0;
            read_add_2             <= '0;
            read_sector_selector_2 <= '0;
            data_write             <= '0;
            sector_write_select    <= '0;
            write_address          <= '0;
        end else begin
            state                  <= state_d;
            cfg                    <= cfg_d;
            cnt                    <= cnt_d;
            j                      <= j_d;
            busy                   <= busy_d;
            done                   <= done_d;
            err                    <= err_d;
            en_write               <= en_write_d;
            read_add_1             <= ra1_d;
            read_sector_selector_1 <= rs1_d;
            read_add_2             <= ra2_d;
            read_sector_selector_2 <= rs2_d;
            data_write             <= dw_d;
            sector_write_select    <= sws_d;
            write_address          <= wa_d;
        end
    end

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Directed bench for layer_mac_sequencer with a behavioural 16x16 sector memory (1-cycle reads).
module tb_layer_mac_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  in_sector = '0, w_sector_base = '0, out_sector = '0, n_inputs = '0;
    logic [4:0]  n_outputs = '0;
    logic        relu_en = 1'b0;
    logic        busy, done, err, en_write;
    logic [3:0]  read_add_1, read_sector_selector_1, read_add_2, read_sector_selector_2;
    logic [3:0]  sector_write_select, write_address;
    logic [15:0] read_data_1 = '0, read_data_2 = '0, data_write;

    logic [15:0] mem [16][16];

    int n_assert = 0;
    int n_fail   = 0;

    int   r_done, r_busy, r_nw, r_post, r_first_wr;
    logic r_err;
    logic [15:0] wr_data [16];
    logic [3:0]  wr_addr [16];
    logic [3:0]  wr_sect [16];
    logic [3:0]  wr_rsel [16];

    layer_mac_sequencer dut (
        .clock                  (clock),
        .reset                  (reset),
        .start                  (start),
        .in_sector              (in_sector),
        .w_sector_base          (w_sector_base),
        .out_sector             (out_sector),
        .n_inputs               (n_inputs),
        .n_outputs              (n_outputs),
        .relu_en                (relu_en),
        .busy                   (busy),
        .done                   (done),
        .err                    (err),
        .read_add_1             (read_add_1),
        .read_sector_selector_1 (read_sector_selector_1),
        .read_add_2             (read_add_2),
        .read_sector_selector_2 (read_sector_selector_2),
        .read_data_1            (read_data_1),
        .read_data_2            (read_data_2),
        .data_write             (data_write),
        .sector_write_select    (sector_write_select),
        .write_address          (write_address),
        .en_write               (en_write)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        read_data_1 <= mem[read_sector_selector_1][read_add_1];
        read_data_2 <= mem[read_sector_selector_2][read_add_2];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle 1 is the first cycle after the accepting edge; config pins are scrambled after accept.
    task automatic run_layer(input logic [3:0] ins, input logic [3:0] wb, input logic [3:0] outs,
                             input logic [3:0] nin, input logic [4:0] nout, input logic relu,
                             input int glitch_at, input int reset_at, input int budget);
        @(negedge clock);
        in_sector = ins; w_sector_base = wb; out_sector = outs;
        n_inputs = nin; n_outputs = nout; relu_en = relu; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        in_sector = 4'd15; w_sector_base = 4'd9; out_sector = 4'd15;
        n_inputs = 4'd0; n_outputs = 5'd0; relu_en = ~relu;
        r_done = -1; r_busy = 0; r_nw = 0; r_post = 0; r_first_wr = -1; r_err = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (reset_at >= 0 && cyc > reset_at && (busy || done || en_write)) r_post++;
            if (busy) r_busy++;
            if (en_write) begin
                if (r_first_wr < 0) r_first_wr = cyc;
                if (r_nw < 16) begin
                    wr_data[r_nw] = data_write;
                    wr_addr[r_nw] = write_address;
                    wr_sect[r_nw] = sector_write_select;
                    wr_rsel[r_nw] = read_sector_selector_2;
                end
                r_nw++;
            end
            if (done) begin
                r_done = cyc;
                r_err  = err;
                break;
            end
            start = (cyc == glitch_at);
            reset = (cyc == reset_at);
            @(negedge clock);
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic expect_error_run(input string tag, input logic [3:0] ins, input logic [3:0] wb,
                                    input logic [3:0] outs, input logic [3:0] nin, input logic [4:0] nout);
        run_layer(ins, wb, outs, nin, nout, 1'b0, -1, -1, 10);
        check({tag, "_done_cyc"}, 32'(r_done), 32'd1);
        check({tag, "_err"}, 32'(r_err), 32'd1);
        check({tag, "_writes"}, 32'(r_nw), 32'd0);
    endtask

    initial begin
        for (int s = 0; s < 16; s++)
            for (int a = 0; a < 16; a++)
                mem[s][a] = 16'h0000;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_flags", 32'({busy, done, err, en_write}), 32'd0);
        check("rst_data_write", 32'(data_write), 32'd0);
        check("rst_read_ports", 32'({read_add_1, read_sector_selector_1, read_add_2, read_sector_selector_2}), 32'd0);
        reset = 1'b0;

        // Single neuron: 1*0.5 + 2*0.25 + 1/16 = 1.0625
        mem[1][0] = 16'h0100; mem[1][1] = 16'h0200;
        mem[2][0] = 16'h0080; mem[2][1] = 16'h0040; mem[2][15] = 16'h0010;
        run_layer(4'd1, 4'd2, 4'd3, 4'd2, 5'd1, 1'b0, -1, -1, 40);
        check("t1_writes", 32'(r_nw), 32'd1);
        check("t1_data", 32'(wr_data[0]), 32'h0110);
        check("t1_addr_sect", 32'({wr_sect[0], wr_addr[0]}), 32'h30);
        check("t1_first_wr_cyc", 32'(r_first_wr), 32'd5);
        check("t1_done_cyc", 32'(r_done), 32'd6);
        check("t1_err", 32'(r_err), 32'd0);
        check("t1_busy_cycles", 32'(r_busy), 32'd6);

        // Negative result, with and without ReLU
        mem[9][0] = 16'h0100;
        mem[5][0] = 16'hFF00; mem[5][15] = 16'h0000;
        run_layer(4'd9, 4'd5, 4'd3, 4'd1, 5'd1, 1'b0, -1, -1, 40);
        check("t2_neg_data", 32'(wr_data[0]), 32'hFF00);
        run_layer(4'd9, 4'd5, 4'd3, 4'd1, 5'd1, 1'b1, -1, -1, 40);
        check("t2_relu_data", 32'(wr_data[0]), 32'h0000);

        // Saturation at both rails
        for (int a = 0; a < 4; a++) begin
            mem[10][a] = 16'h7FFF;
            mem[6][a]  = 16'h7FFF;
            mem[7][a]  = 16'h8001;
        end
        mem[6][15] = 16'h0000; mem[7][15] = 16'h0000;
        run_layer(4'd10, 4'd6, 4'd3, 4'd4, 5'd1, 1'b0, -1, -1, 40);
        check("t3_sat_pos", 32'(wr_data[0]), 32'h7FFF);
        run_layer(4'd10, 4'd7, 4'd3, 4'd4, 5'd1, 1'b0, -1, -1, 40);
        check("t3_sat_neg", 32'(wr_data[0]), 32'h8000);

        // Three neurons from sectors 4..6; a start pulse mid-layer must be ignored
        mem[4][0] = 16'h0100; mem[4][1] = 16'h0000; mem[4][15] = 16'h0000;
        mem[5][0] = 16'h0000; mem[5][1] = 16'h0100; mem[5][15] = 16'h0001;
        mem[6][0] = 16'h0080; mem[6][1] = 16'h0080; mem[6][15] = 16'hFF80;
        run_layer(4'd1, 4'd4, 4'd8, 4'd2, 5'd3, 1'b0, 4, -1, 60);
        check("t4_writes", 32'(r_nw), 32'd3);
        check("t4_data0", 32'(wr_data[0]), 32'h0100);
        check("t4_data1", 32'(wr_data[1]), 32'h0201);
        check("t4_data2", 32'(wr_data[2]), 32'h0100);
        check("t4_addrs", 32'({wr_addr[0], wr_addr[1], wr_addr[2]}), 32'h012);
        check("t4_rd_sects", 32'({wr_rsel[0], wr_rsel[1], wr_rsel[2]}), 32'h456);
        check("t4_wr_sects", 32'({wr_sect[0], wr_sect[1], wr_sect[2]}), 32'h888);
        check("t4_done_cyc", 32'(r_done), 32'd16);
        check("t4_busy_cycles", 32'(r_busy), 32'd16);

        // Start in the done cycle is dropped
        in_sector = 4'd1; w_sector_base = 4'd2; out_sector = 4'd3;
        n_inputs = 4'd2; n_outputs = 5'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_at_done_busy", 32'(busy), 32'd0);
        @(negedge clock);
        check("start_at_done_idle", 32'(busy), 32'd0);

        // Illegal configurations
        expect_error_run("err_rom_out", 4'd1, 4'd2, 4'd15, 4'd2, 5'd1);
        expect_error_run("err_out_eq_in", 4'd1, 4'd2, 4'd1, 4'd2, 5'd1);
        expect_error_run("err_nin_zero", 4'd1, 4'd2, 4'd3, 4'd0, 5'd1);
        expect_error_run("err_w_overrun", 4'd1, 4'd14, 4'd3, 4'd2, 5'd3);

        // Weight range ending exactly at sector 15 is legal
        mem[14][0] = 16'h0200; mem[14][15] = 16'h0000;
        run_layer(4'd9, 4'd14, 4'd3, 4'd1, 5'd2, 1'b0, -1, -1, 40);
        check("edge_w15_err", 32'(r_err), 32'd0);
        check("edge_w15_data", 32'({wr_data[0], wr_data[1]}), 32'h0200_0000);

        // Reset during the drain of the second neuron
        run_layer(4'd10, 4'd6, 4'd3, 4'd4, 5'd2, 1'b0, -1, 13, 30);
        check("rst_mid_writes", 32'(r_nw), 32'd1);
        check("rst_mid_first_data", 32'(wr_data[0]), 32'h7FFF);
        check("rst_mid_post_activity", 32'(r_post), 32'd0);
        check("rst_mid_no_done", 32'(r_done), 32'hFFFF_FFFF);
        check("rst_mid_outputs", 32'({busy, done, err, en_write}), 32'd0);

        // Recovery after reset: accumulator and pipe start clean
        run_layer(4'd1, 4'd2, 4'd3, 4'd2, 5'd1, 1'b0, -1, -1, 40);
        check("recover_data", 32'(wr_data[0]), 32'h0110);
        check("recover_done_cyc", 32'(r_done), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
